// File: rtl/tetris_game_ctrl.sv
// tetris_game_ctrl: top-level game sequencer.
//   Paces gravity drops, locks the active piece on collision, launches one
//   line-clear evaluation per lock and turns the engine's cumulative line
//   count into per-lock deltas, points, level and gravity interval.
//   Optional macro HARD_DROP_EN adds the HDROP state (hard_drop input).
// Ports:
//   clk, reset_n (async, active-low)
//   start, drop_tick, collide_down, spawn_blocked, eval_complete,
//   clear_score[7:0], hard_drop                         -> inputs
//   move_down, lock_piece, start_eval, spawn_req         -> one-cycle pulses
//   lines_cleared, total_lines, points, level,
//   drop_interval, game_over, eval_err                   -> status
// Handshake: every output pulse is a registered single-cycle strobe with no
// acknowledge; eval_complete is only honoured while waiting for the engine.
module tetris_game_ctrl #(
    parameter int DROP_BASE       = 60,
    parameter int DROP_STEP       = 5,
    parameter int DROP_MIN        = 5,
    parameter int LINES_PER_LEVEL = 10,
    parameter int EVAL_TIMEOUT    = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        drop_tick,
    input  logic        collide_down,
    input  logic        spawn_blocked,
    input  logic        eval_complete,
    input  logic [7:0]  clear_score,
    input  logic        hard_drop,
    output logic        move_down,
    output logic        lock_piece,
    output logic        start_eval,
    output logic        spawn_req,
    output logic [2:0]  lines_cleared,
    output logic [15:0] total_lines,
    output logic [19:0] points,
    output logic [4:0]  level,
    output logic [6:0]  drop_interval,
    output logic        game_over,
    output logic        eval_err
);

    localparam int WD_W = $clog2(EVAL_TIMEOUT) + 1;
    localparam int LC_W = $clog2(LINES_PER_LEVEL + 4) + 1;

    typedef enum logic [3:0] {
        S_IDLE, S_SPAWN, S_SPAWN_CHK, S_FALL,
`ifdef HARD_DROP_EN
        S_HDROP,
`endif
        S_LOCK, S_CLEAR_REQ, S_CLEAR_WAIT, S_SCORE, S_GAMEOVER
    } state_t;

    state_t            state_q, state_d;
    logic              move_down_q, move_down_d;
    logic              lock_piece_q, lock_piece_d;
    logic              start_eval_q, start_eval_d;
    logic              spawn_req_q, spawn_req_d;
    logic              game_over_q, game_over_d;
    logic              eval_err_q, eval_err_d;
    logic [2:0]        lines_q, lines_d;
    logic [15:0]       total_q, total_d;
    logic [19:0]       points_q, points_d;
    logic [4:0]        level_q, level_d;
    logic [6:0]        di_q, di_d;
    logic [6:0]        tick_q, tick_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic [7:0]        score_base_q, score_base_d;
    logic [LC_W-1:0]   lvl_cnt_q, lvl_cnt_d;   // lines since last level-up
    logic              hard_bonus;

    // Scratch arithmetic
    logic [7:0]        delta;
    logic [16:0]       total_sum;
    logic [10:0]       tbl_pts;
    logic [17:0]       pts_add;
    logic [20:0]       pts_sum;
    logic [LC_W-1:0]   lc_sum;
    logic [11:0]       drop_red;

`ifdef HARD_DROP_EN
    logic hard_q, hard_d;
    assign hard_bonus = hard_q;
`else
    logic unused_hard_drop;
    assign unused_hard_drop = hard_drop;
    assign hard_bonus       = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        move_down_d  = 1'b0;
        lock_piece_d = 1'b0;
        start_eval_d = 1'b0;
        spawn_req_d  = 1'b0;
        eval_err_d   = eval_err_q;
        lines_d      = lines_q;
        total_d      = total_q;
        points_d     = points_q;
        level_d      = level_q;
        tick_d       = tick_q;
        wdog_d       = wdog_q;
        score_base_d = score_base_q;
        lvl_cnt_d    = lvl_cnt_q;
`ifdef HARD_DROP_EN
        hard_d       = hard_q;
`endif
        // Modulo-256 difference makes the delta immune to engine wrap/base.
        delta     = clear_score - score_base_q;
        total_sum = {1'b0, total_q} + 17'(lines_q);
        case (lines_q)
            3'd1:    tbl_pts = 11'd40;
            3'd2:    tbl_pts = 11'd100;
            3'd3:    tbl_pts = 11'd300;
            3'd4:    tbl_pts = 11'd1200;
            default: tbl_pts = 11'd0;
        endcase
        pts_add = 18'(tbl_pts) * 18'(level_q) + 18'(tbl_pts);
        if (hard_bonus) pts_add = pts_add << 1;
        pts_sum = {1'b0, points_q} + 21'(pts_add);
        lc_sum  = lvl_cnt_q + LC_W'(lines_q);

        drop_red = 12'(level_q) * 12'(DROP_STEP);
        if (drop_red + 12'(DROP_MIN) >= 12'(DROP_BASE)) di_d = 7'(DROP_MIN);
        else                                             di_d = 7'(12'(DROP_BASE) - drop_red);

        case (state_q)
            S_IDLE, S_GAMEOVER: begin
                if (start) begin
                    lines_d     = 3'd0;
                    total_d     = 16'd0;
                    points_d    = 20'd0;
                    level_d     = 5'd0;
                    lvl_cnt_d   = '0;
                    eval_err_d  = 1'b0;
                    state_d     = S_SPAWN;
                    spawn_req_d = 1'b1;
                end
            end
            S_SPAWN: begin
                tick_d  = 7'd0;
                state_d = S_SPAWN_CHK;
            end
            S_SPAWN_CHK: begin
                tick_d  = 7'd0;
                state_d = spawn_blocked ? S_GAMEOVER : S_FALL;
            end
            S_FALL: begin
`ifdef HARD_DROP_EN
                if (hard_drop) begin
                    hard_d  = 1'b1;
                    state_d = S_HDROP;
                end else
`endif
                if (drop_tick) begin
                    if ({1'b0, tick_q} + 8'd1 >= {1'b0, di_q}) begin
                        tick_d = 7'd0;
                        if (collide_down) begin
                            state_d      = S_LOCK;
                            lock_piece_d = 1'b1;
                        end else begin
                            move_down_d = 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 7'd1;
                    end
                end
            end
`ifdef HARD_DROP_EN
            S_HDROP: begin
                if (collide_down) begin
                    state_d      = S_LOCK;
                    lock_piece_d = 1'b1;
                end else begin
                    move_down_d = 1'b1;
                end
            end
`endif
            S_LOCK: begin
                state_d      = S_CLEAR_REQ;
                start_eval_d = 1'b1;
            end
            S_CLEAR_REQ: begin
                score_base_d = clear_score;
                wdog_d       = '0;
                state_d      = S_CLEAR_WAIT;
            end
            S_CLEAR_WAIT: begin
                // Completion wins over a coincident timeout.
                if (eval_complete) begin
                    lines_d = (delta > 8'd4) ? 3'd4 : delta[2:0];
                    state_d = S_SCORE;
                end else if (wdog_q == WD_W'(EVAL_TIMEOUT - 1)) begin
                    lines_d     = 3'd0;
                    eval_err_d  = 1'b1;
`ifdef HARD_DROP_EN
                    hard_d      = 1'b0;
`endif
                    state_d     = S_SPAWN;
                    spawn_req_d = 1'b1;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            S_SCORE: begin
                total_d  = total_sum[16] ? 16'hFFFF : total_sum[15:0];
                points_d = pts_sum[20] ? 20'hFFFFF : pts_sum[19:0];
                // At most one level-up per lock since lines_q <= 4.
                if (lc_sum >= LC_W'(LINES_PER_LEVEL)) begin
                    lvl_cnt_d = lc_sum - LC_W'(LINES_PER_LEVEL);
                    level_d   = (level_q == 5'd31) ? 5'd31 : level_q + 5'd1;
                end else begin
                    lvl_cnt_d = lc_sum;
                end
`ifdef HARD_DROP_EN
                hard_d      = 1'b0;
`endif
                state_d     = S_SPAWN;
                spawn_req_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        game_over_d = (state_d == S_GAMEOVER);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            move_down_q  <= 1'b0;
            lock_piece_q <= 1'b0;
            start_eval_q <= 1'b0;
            spawn_req_q  <= 1'b0;
            game_over_q  <= 1'b0;
            eval_err_q   <= 1'b0;
            lines_q      <= 3'd0;
            total_q      <= 16'd0;
            points_q     <= 20'd0;
            level_q      <= 5'd0;
            di_q         <= 7'(DROP_BASE);
            tick_q       <= 7'd0;
            wdog_q       <= '0;
            score_base_q <= 8'd0;
            lvl_cnt_q    <= '0;
`ifdef HARD_DROP_EN
            hard_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            move_down_q  <= move_down_d;
            lock_piece_q <= lock_piece_d;
            start_eval_q <= start_eval_d;
            spawn_req_q  <= spawn_req_d;
            game_over_q  <= game_over_d;
            eval_err_q   <= eval_err_d;
            lines_q      <= lines_d;
            total_q      <= total_d;
            points_q     <= points_d;
            level_q      <= level_d;
            di_q         <= di_d;
            tick_q       <= tick_d;
            wdog_q       <= wdog_d;
            score_base_q <= score_base_d;
            lvl_cnt_q    <= lvl_cnt_d;
`ifdef HARD_DROP_EN
            hard_q       <= hard_d;
`endif
        end
    end

    assign move_down     = move_down_q;
    assign lock_piece    = lock_piece_q;
    assign start_eval    = start_eval_q;
    assign spawn_req     = spawn_req_q;
    assign lines_cleared = lines_q;
    assign total_lines   = total_q;
    assign points        = points_q;
    assign level         = level_q;
    assign drop_interval = di_q;
    assign game_over     = game_over_q;
    assign eval_err      = eval_err_q;

endmodule

// File: tb/tb_tetris_game_ctrl.sv
module tb_tetris_game_ctrl;
  localparam int DB  = 20;
  localparam int DS  = 5;
  localparam int DM  = 5;
  localparam int LPL = 10;
  localparam int TO  = 64;
  localparam int W   = 58;

  localparam logic [4:0] K_SPAWN = 5'b10000;
  localparam logic [4:0] K_MOVE  = 5'b01000;
  localparam logic [4:0] K_LOCK  = 5'b00100;
  localparam logic [4:0] K_EVAL  = 5'b00010;
  localparam logic [4:0] K_GO    = 5'b00001;

  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, drop_tick = 1'b0;
  logic collide_down = 1'b0, spawn_blocked = 1'b0, eval_complete = 1'b0;
  logic hard_drop = 1'b0;
  logic [7:0] clear_score = 8'd0;
  logic move_down, lock_piece, start_eval, spawn_req, game_over, eval_err;
  logic [2:0] lines_cleared;
  logic [15:0] total_lines;
  logic [19:0] points;
  logic [4:0] level;
  logic [6:0] drop_interval;

  tetris_game_ctrl #(
    .DROP_BASE(DB), .DROP_STEP(DS), .DROP_MIN(DM),
    .LINES_PER_LEVEL(LPL), .EVAL_TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .drop_tick(drop_tick),
    .collide_down(collide_down), .spawn_blocked(spawn_blocked),
    .eval_complete(eval_complete), .clear_score(clear_score),
    .hard_drop(hard_drop), .move_down(move_down), .lock_piece(lock_piece),
    .start_eval(start_eval), .spawn_req(spawn_req),
    .lines_cleared(lines_cleared), .total_lines(total_lines), .points(points),
    .level(level), .drop_interval(drop_interval), .game_over(game_over),
    .eval_err(eval_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // reference model: game rules at the transaction level
  int lines_m = 0, total_m = 0, points_m = 0, level_m = 0, lvl_before = 0;
  logic err_m = 1'b0;
  logic [7:0] eng_score = 8'd0;

  function automatic int di_of(input int l);
    int v;
    v = DB - l * DS;
    return (v < DM) ? DM : v;
  endfunction

  function automatic int tbl(input int n);
    case (n)
      1: return 40;
      2: return 100;
      3: return 300;
      4: return 1200;
      default: return 0;
    endcase
  endfunction

  function automatic string kname(input logic [4:0] k);
    case (k)
      K_SPAWN: return "spawn_req";
      K_MOVE:  return "move_down";
      K_LOCK:  return "lock_piece";
      K_EVAL:  return "start_eval";
      K_GO:    return "game_over";
      default: return "event";
    endcase
  endfunction

  task automatic push(input logic [4:0] kind, input int di, input logic go);
    exp_q.push_back({kind, 3'(lines_m), 16'(total_m), 20'(points_m),
                     5'(level_m), 7'(di), err_m, go});
  endtask

  // monitor / scoreboard
  logic go_prev = 1'b0;
  logic [4:0] mon_k;
  logic [W-1:0] mon_act, mon_exp;
  always @(negedge clk) begin
    mon_k = {spawn_req, move_down, lock_piece, start_eval, game_over & ~go_prev};
    go_prev <= game_over;
    if (mon_k != 5'd0) begin
      mon_act = {mon_k, lines_cleared, total_lines, points, level,
                 drop_interval, eval_err, game_over};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got %h required none", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          errors++;
          $display("FAIL %s: got %h required %h", kname(mon_exp[W-1 -: 5]), mon_act, mon_exp);
        end
      end
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  function automatic logic sel(input int which);
    case (which)
      0: return spawn_req;
      1: return start_eval;
      default: return game_over;
    endcase
  endfunction

  task automatic wait_sig(input int which, input string name);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (sel(which)) begin
        found = 1'b1;
        break;
      end
      cyc();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL wait_%s: got timeout required pulse", name);
    end
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_lines"}, int'(lines_cleared), lines_m);
    chk({tag, "_total"}, int'(total_lines), total_m);
    chk({tag, "_points"}, int'(points), points_m);
    chk({tag, "_level"}, int'(level), level_m);
    chk({tag, "_interval"}, int'(drop_interval), di_of(level_m));
    chk({tag, "_eval_err"}, int'(eval_err), int'(err_m));
  endtask

  task automatic noise();
    repeat ($urandom_range(0, 2)) begin
      start = ($urandom_range(0, 5) == 0);
      eval_complete = ($urandom_range(0, 5) == 0);
`ifndef HARD_DROP_EN
      hard_drop = ($urandom_range(0, 5) == 0);
`endif
      cyc();
      start = 1'b0;
      eval_complete = 1'b0;
      hard_drop = 1'b0;
    end
  endtask

  // one gravity interval worth of ticks; the last one triggers 'kind'
  task automatic advance(input logic [4:0] kind);
    int di;
    di = di_of(level_m);
    for (int t = 0; t < di; t++) begin
      noise();
      if (t == di - 1) begin
        push(kind, di, 1'b0);
        if (kind == K_LOCK) push(K_EVAL, di, 1'b0);
      end
      drop_tick = 1'b1;
      cyc();
      drop_tick = 1'b0;
    end
  endtask

  task automatic do_start();
    lvl_before = level_m;
    lines_m = 0; total_m = 0; points_m = 0; level_m = 0; err_m = 1'b0;
    push(K_SPAWN, di_of(lvl_before), 1'b0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_sig(0, "spawn");
    cyc();
    cyc();
  endtask

  task automatic play_piece(input int moves, input int delta, input int delay,
                            input logic timeout, input logic blocked);
    int l, nt, p;
    collide_down = 1'b0;
    repeat (moves) advance(K_MOVE);
    collide_down = 1'b1;
    advance(K_LOCK);
    wait_sig(1, "start_eval");
    collide_down = 1'b0;
    cyc();
    spawn_blocked = blocked;
    lvl_before = level_m;
    if (timeout) begin
      lines_m = 0;
      err_m = 1'b1;
      push(K_SPAWN, di_of(lvl_before), 1'b0);
    end else begin
      repeat (delay) cyc();
      l = (delta > 4) ? 4 : delta;
      nt = total_m + l;
      p = points_m + tbl(l) * (level_m + 1);
      if (nt / LPL != total_m / LPL) level_m = (level_m >= 31) ? 31 : level_m + 1;
      total_m = (nt > 16'hFFFF) ? 16'hFFFF : nt;
      points_m = (p > 20'hFFFFF) ? 20'hFFFFF : p;
      lines_m = l;
      push(K_SPAWN, di_of(lvl_before), 1'b0);
      eng_score = eng_score + 8'(delta);
      clear_score = eng_score;
      eval_complete = 1'b1;
      cyc();
      eval_complete = 1'b0;
    end
    if (blocked) begin
      push(K_GO, di_of(level_m), 1'b1);
      wait_sig(2, "game_over");
    end else begin
      wait_sig(0, "spawn");
      cyc();
      cyc();
    end
  endtask

  task automatic freeze_check(input string tag);
    repeat (20) begin
      drop_tick = ($urandom_range(0, 1) == 1);
      collide_down = ($urandom_range(0, 1) == 1);
      eval_complete = ($urandom_range(0, 3) == 0);
      cyc();
    end
    drop_tick = 1'b0;
    collide_down = 1'b0;
    eval_complete = 1'b0;
    check_status(tag);
    chk({tag, "_game_over"}, int'(game_over), 1);
    spawn_blocked = 1'b0;
  endtask

  task automatic play_game(input int n, input int to_idx, input int slow_idx);
    int delta;
    for (int p = 0; p < n; p++) begin
      delta = (p < 3) ? 4 : $urandom_range(0, 4);
      if (p % 5 == 3) delta = $urandom_range(5, 9);
      play_piece($urandom_range(0, 2), delta,
                 (p == slow_idx) ? TO - 1 : $urandom_range(0, 10),
                 p == to_idx, p == n - 1);
    end
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_spawn_req"}, int'(spawn_req), 0);
    chk({tag, "_move_down"}, int'(move_down), 0);
    chk({tag, "_lock_piece"}, int'(lock_piece), 0);
    chk({tag, "_start_eval"}, int'(start_eval), 0);
    chk({tag, "_game_over"}, int'(game_over), 0);
    chk({tag, "_lines"}, int'(lines_cleared), 0);
    chk({tag, "_total"}, int'(total_lines), 0);
    chk({tag, "_points"}, int'(points), 0);
    chk({tag, "_level"}, int'(level), 0);
    chk({tag, "_interval"}, int'(drop_interval), DB);
    chk({tag, "_eval_err"}, int'(eval_err), 0);
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) cyc();
    reset_check("reset");
    reset_n = 1'b1;
    cyc();

    // engine score starts near the top so the first deltas wrap mod 256
    eng_score = 8'd255;
    clear_score = eng_score;

    do_start();
    play_game(12, 4, 6);
    freeze_check("frozen1");

    do_start();
    play_game(7, 2, 5);
    freeze_check("frozen2");

    // reset in the middle of a fall
    do_start();
    repeat (3) begin
      drop_tick = 1'b1;
      cyc();
      drop_tick = 1'b0;
      cyc();
    end
    reset_n = 1'b0;
    #2;
    reset_check("midreset");
    reset_n = 1'b1;
    repeat (5) cyc();

    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tetris_game_ctrl.md
Name: tetris_game_ctrl

Overview:
- Top-level game sequencer that drives the line-clear engine and the piece datapath.
- Paces gravity drops, locks the active piece on collision, and launches one line-clear evaluation per lock.
- Converts the engine's cumulative line count into per-lock line deltas, points, level and gravity interval.
- Detects game over when a spawn is blocked.

Parameters:
- DROP_BASE, 60: gravity interval in drop_tick units at level 0.
- DROP_STEP, 5: interval reduction per level.
- DROP_MIN, 5: interval floor.
- LINES_PER_LEVEL, 10: cleared lines per level increment.
- EVAL_TIMEOUT, 64: max cycles to wait for eval_complete.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  start/restart request, level-sensitive
- drop_tick  in  1  one-cycle gravity timebase strobe
- collide_down  in  1  active piece cannot move down (combinational from collision checker)
- spawn_blocked  in  1  spawn location occupied, valid in SPAWN
- eval_complete  in  1  line-clear engine done pulse
- clear_score  in  8  line-clear engine cumulative line count
- hard_drop  in  1  hard-drop request (used only with HARD_DROP_EN)
- move_down  out  1  one-cycle pulse: shift piece down one row
- lock_piece  out  1  one-cycle pulse: merge piece into board
- start_eval  out  1  one-cycle pulse to line-clear engine
- spawn_req  out  1  one-cycle pulse: spawn next piece
- lines_cleared  out  3  lines removed by last lock, 0..4
- total_lines  out  16  saturating line total
- points  out  20  saturating score
- level  out  5  saturating at 31
- drop_interval  out  7  current gravity interval
- game_over  out  1  high in GAMEOVER
- eval_err  out  1  sticky watchdog flag, cleared on start

Behaviour:
- Reset: state IDLE; all pulses 0; lines_cleared, total_lines, points, level, eval_err = 0; drop_interval = DROP_BASE; game_over = 0.
- IDLE:
  - start=1 clears the counters and eval_err, then goes to SPAWN.
- SPAWN:
  - spawn_req = 1 for exactly one cycle.
  - Next cycle samples spawn_blocked: 1 goes to GAMEOVER, 0 goes to FALL.
  - The gravity tick counter is cleared here.
- FALL:
  - Each drop_tick increments tick_cnt.
  - When tick_cnt+1 >= drop_interval on a drop_tick, tick_cnt returns to 0, then:
    - collide_down=0: pulse move_down, stay in FALL.
    - collide_down=1: go to LOCK.
  - drop_tick without reaching the interval has no other effect.
- LOCK:
  - lock_piece = 1 for one cycle, then go to CLEAR_REQ.
- CLEAR_REQ:
  - start_eval = 1 for one cycle.
  - Latch score_base = clear_score and clear the watchdog.
  - Go to CLEAR_WAIT.
- CLEAR_WAIT:
  - On eval_complete: delta = clear_score - score_base (mod 256), clamped to 4, written to lines_cleared; go to SCORE.
  - If EVAL_TIMEOUT cycles elapse first: lines_cleared = 0, eval_err = 1; go to SPAWN.
- SCORE (one cycle):
  - total_lines += lines_cleared, saturating at 0xFFFF.
  - points += table[lines_cleared] * (level+1), saturating at 0xFFFFF. Table: 0, 40, 100, 300, 1200.
  - A level-up occurs when the total crosses a multiple of LINES_PER_LEVEL (at most one per lock); level increments, saturating at 31.
  - Then go to SPAWN.
- drop_interval:
  - Registered; equals max(DROP_MIN, DROP_BASE - level*DROP_STEP).
  - Updates on the cycle after level changes.
- GAMEOVER:
  - game_over = 1; counters frozen.
  - start=1 goes to IDLE-equivalent restart, i.e. clears counters and goes to SPAWN.
- Simultaneous events:
  - start outside IDLE/GAMEOVER is ignored.
  - An eval_complete arriving in the same cycle as the timeout counts as complete.
  - eval_complete outside CLEAR_WAIT is ignored.
- Reset mid-operation returns to the reset values immediately. The line-clear engine's own score is not reset by this block; the delta scheme tolerates any base value.

Optional Feature:
- Macro: HARD_DROP_EN.
- Defined:
  - In FALL, hard_drop=1 enters HDROP.
  - HDROP pulses move_down every cycle while collide_down=0, then goes to LOCK when collide_down=1.
  - Hard-drop lines earn double table points.
- Undefined: hard_drop is ignored and HDROP does not exist.

Test Plan:
- Reset, then start pulse -> spawn_req pulse 1 cycle later; spawn_blocked=0 -> FALL; level=0, drop_interval=60.
- DROP_BASE=3, collide_down=0, 3 drop_ticks -> exactly one move_down pulse; 6 ticks -> two pulses.
- collide_down=1 at interval -> lock_piece, then start_eval on the next cycle; clear_score steps 10->13 with eval_complete -> lines_cleared=3, points=300, total_lines=3.
- total_lines=8, lock clearing 2 lines (clear_score 255->1 wrap) -> lines_cleared=2, level=1, drop_interval=55, points += 100.
- eval_complete withheld for 64 cycles -> eval_err=1, lines_cleared=0, spawn_req pulse; next start clears eval_err.
- spawn_blocked=1 in SPAWN -> game_over=1, counters frozen across ticks; start -> counters 0, spawn_req pulse.
